// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register.
// Holds the operation-mode encoding, the sequencer state type and a helper
// that tells which modes may be run as multi-step bursts.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_SHR    = 3'b001;
    localparam logic [2:0] MODE_SHL    = 3'b010;
    localparam logic [2:0] MODE_ROR    = 3'b011;
    localparam logic [2:0] MODE_ROL    = 3'b100;
    localparam logic [2:0] MODE_LOAD   = 3'b101;
    localparam logic [2:0] MODE_ASR    = 3'b110;
    localparam logic [2:0] MODE_CLEAR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Only the movement modes make sense repeated; hold/load/clear are
    // idempotent and always run as a single step.
    function automatic logic is_burst_mode(input logic [2:0] mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
               (mode == MODE_ROL) || (mode == MODE_ASR);
    endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Control/data bundle of the universal shift register.
// master: the block driving mode, data, serial and burst controls.
// slave : the register itself, returning data, serial taps and Busy/Done.
interface universal_shift_register_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             Enable_In;
    logic [2:0]       Mode_In;
    logic [WIDTH-1:0] Parallel_Data_In;
    logic             Serial_Left_In;
    logic             Serial_Right_In;
    logic             Start_In;
    logic [CNT_W-1:0] Count_In;
    logic [WIDTH-1:0] Parallel_Data_Out;
    logic             Serial_Left_Out;
    logic             Serial_Right_Out;
    logic             Busy_Out;
    logic             Done_Out;

    modport master (
        output Enable_In, Mode_In, Parallel_Data_In, Serial_Left_In,
               Serial_Right_In, Start_In, Count_In,
        input  Parallel_Data_Out, Serial_Left_Out, Serial_Right_Out,
               Busy_Out, Done_Out
    );

    modport slave (
        input  Enable_In, Mode_In, Parallel_Data_In, Serial_Left_In,
               Serial_Right_In, Start_In, Count_In,
        output Parallel_Data_Out, Serial_Left_Out, Serial_Right_Out,
               Busy_Out, Done_Out
    );
endinterface

// File: rtl/universal_shift_register_step.sv
// Combinational next-value unit: one step of the selected mode.
// Ports: i_data current value, i_mode operation, i_load parallel value,
//        i_serial_left MSB fill for shift right, i_serial_right LSB fill
//        for shift left, o_data resulting value.
module shift_register_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_load,
    input  logic             i_serial_left,
    input  logic             i_serial_right,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_mode)
            MODE_HOLD:  o_data = i_data;
            MODE_SHR:   o_data = {i_serial_left, i_data[WIDTH-1:1]};
            MODE_SHL:   o_data = {i_data[WIDTH-2:0], i_serial_right};
            MODE_ROR:   o_data = {i_data[0], i_data[WIDTH-1:1]};
            MODE_ROL:   o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
            MODE_LOAD:  o_data = i_load;
            MODE_ASR:   o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
            MODE_CLEAR: o_data = '0;
            default:    o_data = i_data;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with burst sequencer.
// Ports: Clk_In (state updates on falling edge), Reset_In (async, high),
//        bus (slave side of universal_shift_register_if): mode/data/serial
//        inputs, Start/Count burst launch, data out, serial taps, Busy/Done.
// State | meaning
// IDLE  | one step of Mode_In per enabled edge; Start may launch a burst
// RUN   | burst in progress, latched mode stepped until the counter empties
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic Clk_In,
    input  logic Reset_In,
    universal_shift_register_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_mode, w_mode_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic             r_busy, r_done, w_done_nxt;
    logic [2:0]       w_step_mode;
    logic [WIDTH-1:0] w_step_data;

    // Inside a burst the latched mode drives the datapath, not Mode_In.
    assign w_step_mode = (r_state == ST_RUN) ? r_mode : bus.Mode_In;

    shift_register_step #(.WIDTH(WIDTH)) u_step (
        .i_data         (r_data),
        .i_mode         (w_step_mode),
        .i_load         (bus.Parallel_Data_In),
        .i_serial_left  (bus.Serial_Left_In),
        .i_serial_right (bus.Serial_Right_In),
        .o_data         (w_step_data)
    );

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_HOLD;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        if (bus.Enable_In) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start_In && is_burst_mode(bus.Mode_In)) begin
                        w_mode_nxt = bus.Mode_In;
                        if (bus.Count_In == '0) begin
                            w_done_nxt = 1'b1;
                        end else if (bus.Count_In == CNT_ONE) begin
                            w_data_nxt = w_step_data;
                            w_done_nxt = 1'b1;
                        end else begin
                            // First step happens on the launch edge itself.
                            w_data_nxt  = w_step_data;
                            w_cnt_nxt   = bus.Count_In - CNT_ONE;
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_data_nxt = w_step_data;
                    end
                end
                ST_RUN: begin
                    w_data_nxt = w_step_data;
                    w_cnt_nxt  = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.Parallel_Data_Out = r_data;
    assign bus.Serial_Left_Out   = r_data[WIDTH-1];
    assign bus.Serial_Right_Out  = r_data[0];
    assign bus.Busy_Out          = r_busy;
    assign bus.Done_Out          = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;
    import usr_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   busy_n;
    int   done_n;
    int   done_edge;

    universal_shift_register_if #(.WIDTH(16)) bus ();

    universal_shift_register #(.WIDTH(16)) dut (
        .Clk_In   (clk),
        .Reset_In (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one falling edge and sample shortly after it.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        bus.Mode_In          = MODE_LOAD;
        bus.Start_In         = 1'b0;
        bus.Parallel_Data_In = v;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.Enable_In        = 1'b1;
        bus.Mode_In          = MODE_HOLD;
        bus.Parallel_Data_In = '0;
        bus.Serial_Left_In   = 1'b0;
        bus.Serial_Right_In  = 1'b0;
        bus.Start_In         = 1'b0;
        bus.Count_In         = '0;
        #3;
        chk("rst_data", 32'(bus.Parallel_Data_Out), 32'h0);
        chk("rst_busy", 32'(bus.Busy_Out), 32'h0);
        chk("rst_done", 32'(bus.Done_Out), 32'h0);
        #4 rst = 1'b0;

        // Burst rotate-left x4 from 0xA5C3
        load(16'hA5C3);
        chk("load_a5c3", 32'(bus.Parallel_Data_Out), 32'hA5C3);
        bus.Mode_In  = MODE_ROL;
        bus.Start_In = 1'b1;
        bus.Count_In = 5'd4;
        tick();
        chk("rol_edge0", 32'(bus.Parallel_Data_Out), 32'h4B87);
        chk("rol_busy0", 32'(bus.Busy_Out), 32'h1);
        busy_n = 1;
        done_n = 0;
        bus.Start_In = 1'b0;
        bus.Mode_In  = MODE_HOLD;
        for (int i = 1; i <= 5; i++) begin
            tick();
            busy_n += int'(bus.Busy_Out);
            done_n += int'(bus.Done_Out);
            if (bus.Done_Out) chk("rol_done_data", 32'(bus.Parallel_Data_Out), 32'h5C3A);
        end
        chk("rol_busy_cycles", 32'(busy_n), 32'd3);
        chk("rol_done_pulses", 32'(done_n), 32'd1);
        chk("rol_final", 32'(bus.Parallel_Data_Out), 32'h5C3A);

        // Arithmetic shift right burst x3
        load(16'h8000);
        bus.Mode_In  = MODE_ASR;
        bus.Start_In = 1'b1;
        bus.Count_In = 5'd3;
        tick();
        bus.Start_In = 1'b0;
        bus.Mode_In  = MODE_HOLD;
        tick();
        tick();
        chk("asr_data", 32'(bus.Parallel_Data_Out), 32'hF000);
        chk("asr_done", 32'(bus.Done_Out), 32'h1);
        chk("asr_busy", 32'(bus.Busy_Out), 32'h0);

        // Logical shift right single steps x3
        load(16'h8000);
        bus.Mode_In        = MODE_SHR;
        bus.Serial_Left_In = 1'b0;
        repeat (3) tick();
        chk("shr_data", 32'(bus.Parallel_Data_Out), 32'h1000);
        chk("shr_busy", 32'(bus.Busy_Out), 32'h0);

        // Count=1 burst, then Enable low clears Done
        bus.Mode_In         = MODE_SHL;
        bus.Serial_Right_In = 1'b0;
        bus.Start_In        = 1'b1;
        bus.Count_In        = 5'd1;
        tick();
        chk("cnt1_data", 32'(bus.Parallel_Data_Out), 32'h2000);
        chk("cnt1_done", 32'(bus.Done_Out), 32'h1);
        chk("cnt1_busy", 32'(bus.Busy_Out), 32'h0);
        bus.Enable_In = 1'b0;
        tick();
        chk("dis_done", 32'(bus.Done_Out), 32'h0);
        chk("dis_data", 32'(bus.Parallel_Data_Out), 32'h2000);
        bus.Enable_In = 1'b1;

        // Start with a non-burst mode is a plain load
        bus.Mode_In          = MODE_LOAD;
        bus.Parallel_Data_In = 16'h1234;
        bus.Count_In         = 5'd5;
        tick();
        chk("nb_data", 32'(bus.Parallel_Data_Out), 32'h1234);
        chk("nb_busy", 32'(bus.Busy_Out), 32'h0);
        chk("nb_done", 32'(bus.Done_Out), 32'h0);
        bus.Start_In = 1'b0;

        // From reset: shift left x16 with ones
        rst = 1'b1;
        #2 rst = 1'b0;
        bus.Mode_In         = MODE_SHL;
        bus.Serial_Right_In = 1'b1;
        tick();
        chk("shl_first", 32'(bus.Parallel_Data_Out), 32'h0001);
        chk("shl_sro", 32'(bus.Serial_Right_Out), 32'h1);
        chk("shl_slo0", 32'(bus.Serial_Left_Out), 32'h0);
        repeat (15) tick();
        chk("shl_full", 32'(bus.Parallel_Data_Out), 32'hFFFF);
        chk("shl_slo1", 32'(bus.Serial_Left_Out), 32'h1);

        // Burst of 8 rotate-right stalled for 3 edges; Mode changes ignored
        load(16'h0001);
        bus.Mode_In  = MODE_ROR;
        bus.Start_In = 1'b1;
        bus.Count_In = 5'd8;
        done_edge = 0;
        for (int e = 1; e <= 11; e++) begin
            bus.Enable_In = !(e >= 4 && e <= 6);
            tick();
            if (e == 1) begin
                bus.Start_In = 1'b0;
                bus.Mode_In  = MODE_CLEAR;
            end
            if (bus.Done_Out && done_edge == 0) done_edge = e;
            if (e == 6) begin
                chk("stall_data", 32'(bus.Parallel_Data_Out), 32'h2000);
                chk("stall_busy", 32'(bus.Busy_Out), 32'h1);
            end
        end
        chk("stall_done_edge", 32'(done_edge), 32'd11);
        chk("stall_final", 32'(bus.Parallel_Data_Out), 32'h0100);
        bus.Enable_In = 1'b1;

        // Reset mid-burst, then a Count=0 start
        load(16'h00FF);
        bus.Mode_In  = MODE_ROR;
        bus.Start_In = 1'b1;
        bus.Count_In = 5'd8;
        tick();
        bus.Start_In = 1'b0;
        tick();
        chk("pre_rst_busy", 32'(bus.Busy_Out), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_data", 32'(bus.Parallel_Data_Out), 32'h0);
        chk("midrst_busy", 32'(bus.Busy_Out), 32'h0);
        chk("midrst_done", 32'(bus.Done_Out), 32'h0);
        rst = 1'b0;
        bus.Mode_In  = MODE_SHR;
        bus.Start_In = 1'b1;
        bus.Count_In = 5'd0;
        tick();
        chk("cnt0_done", 32'(bus.Done_Out), 32'h1);
        chk("cnt0_data", 32'(bus.Parallel_Data_Out), 32'h0);
        chk("cnt0_busy", 32'(bus.Busy_Out), 32'h0);
        bus.Start_In = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
